mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS32 core. It takes `OpCode`/`Funct` from the instruction decoder and the ALU `Zero` flag, sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It also handshakes with the unified instruction/data memory port and counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_ctrl_if.sv | 30 +++
 rtl/mc_ctrl_outdec.sv | 79 +++++++
 rtl/mc_ctrl.sv | 54 +++++
 tb/tb_mc_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode/funct and control-code definitions shared by the multi-cycle controller
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_BRANCH, S_JUMP
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                           OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
                           OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADD = 6'h20,
                           FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2a,
                           FN_SLTU = 6'h2b;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10, ALU_IMM = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11;
    localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM4 = 2'b11;
    localparam logic [1:0] DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10;
    localparam logic [1:0] WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10;

    // S_FETCH doubles as the "unsupported instruction" result
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
        state_t s;
        s = S_FETCH;
        case (op)
            OP_RTYPE:
                case (funct)
                    FN_JR: s = S_JUMP;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU, FN_SLL, FN_SRL: s = S_EXEC_R;
                    default: s = S_FETCH;
                endcase
            OP_LW, OP_SW: s = S_MEMADR;
            OP_BEQ, OP_BNE: s = S_BRANCH;
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: s = S_EXEC_I;
            OP_J, OP_JAL: s = S_JUMP;
            default: s = S_FETCH;
        endcase
        return s;
    endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bus between the multi-cycle FSM and the datapath/memory port
interface mc_ctrl_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       Illegal;
    modport master (
        input  OpCode, Funct, Zero, MemReady,
        output MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, RegDst, MemtoReg, Illegal
    );
    modport slave (
        output OpCode, Funct, Zero, MemReady,
        input  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, RegDst, MemtoReg, Illegal
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational decode of FSM state into every datapath enable and mux select
module mc_ctrl_outdec import mc_ctrl_pkg::*; (
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic [5:0] funct_q,
    mc_ctrl_if.master  bus
);
    always_comb begin
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSource = PC_ALU;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = SRCB_B;
        bus.ALUOp    = ALU_ADD;
        bus.RegWrite = 1'b0;
        bus.RegDst   = DST_RT;
        bus.MemtoReg = WB_ALU;
        bus.Illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
                bus.ALUSrcB = SRCB_4;
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM4;
                bus.Illegal = decode_next(bus.OpCode, bus.Funct) == S_FETCH;
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = WB_MDR;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = ALU_FUNCT;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = DST_RD;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ALUOp   = ALU_IMM;
            end
            S_IWB: bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALU_SUB;
                bus.PCSource = PC_ALUOUT;
                bus.PCWrite  = (op_q == OP_BEQ && bus.Zero) || (op_q == OP_BNE && !bus.Zero);
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = (op_q == OP_RTYPE && funct_q == FN_JR) ? PC_RS : PC_JUMP;
                bus.RegWrite = op_q == OP_JAL;
                bus.RegDst   = op_q == OP_JAL ? DST_R31 : DST_RT;
                bus.MemtoReg = op_q == OP_JAL ? WB_PC : WB_ALU;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS32 control FSM with opcode latch and retired-instruction counter
module mc_ctrl import mc_ctrl_pkg::*; #(
    parameter int RETIRE_W = 32
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mc_ctrl_if.master           bus,
    output logic [RETIRE_W-1:0] RetireCnt
);
    state_t     state, next;
    logic [5:0] op_q, funct_q;
    logic       retire;

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:  next = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: next = decode_next(bus.OpCode, bus.Funct);
            S_MEMADR: next = op_q == OP_SW ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next = bus.MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next = bus.MemReady ? S_FETCH : S_MEMWR;
            S_EXEC_R: next = S_RWB;
            S_EXEC_I: next = S_IWB;
            default:  next = S_FETCH;
        endcase
    end

    // Illegal instructions return to FETCH from DECODE and are deliberately not counted
    assign retire = next == S_FETCH &&
                    (state inside {S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP});

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            RetireCnt <= '0;
            op_q      <= '0;
            funct_q   <= '0;
        end else begin
            state <= next;
            if (retire) RetireCnt <= RetireCnt + RETIRE_W'(1);
            if (state == S_DECODE) begin
                op_q    <= bus.OpCode;
                funct_q <= bus.Funct;
            end
        end
    end

    mc_ctrl_outdec u_outdec (
        .state   (state),
        .op_q    (op_q),
        .funct_q (funct_q),
        .bus     (bus)
    );
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle scoreboard bench for mc_ctrl, with a 2-bit-counter twin for wrap
module tb_mc_ctrl;
    typedef struct {
        string       nm;
        logic [17:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    // field order: MemRead MemWrite IorD IRWrite PCWrite _ PCSource _ ALUSrcA _ ALUSrcB _ ALUOp _ RegWrite _ RegDst _ MemtoReg _ Illegal
    localparam logic [17:0] C_IDLE    = 18'b00000_00_0_00_00_0_00_00_0;
    localparam logic [17:0] C_FETCH   = 18'b10011_00_0_01_00_0_00_00_0;
    localparam logic [17:0] C_FETCH_W = 18'b10000_00_0_01_00_0_00_00_0;
    localparam logic [17:0] C_DECODE  = 18'b00000_00_0_11_00_0_00_00_0;
    localparam logic [17:0] C_DEC_ILL = 18'b00000_00_0_11_00_0_00_00_1;
    localparam logic [17:0] C_MEMADR  = 18'b00000_00_1_10_00_0_00_00_0;
    localparam logic [17:0] C_MEMRD   = 18'b10100_00_0_00_00_0_00_00_0;
    localparam logic [17:0] C_MEMWB   = 18'b00000_00_0_00_00_1_00_01_0;
    localparam logic [17:0] C_MEMWR   = 18'b01100_00_0_00_00_0_00_00_0;
    localparam logic [17:0] C_EXEC_R  = 18'b00000_00_1_00_10_0_00_00_0;
    localparam logic [17:0] C_RWB     = 18'b00000_00_0_00_00_1_01_00_0;
    localparam logic [17:0] C_EXEC_I  = 18'b00000_00_1_10_11_0_00_00_0;
    localparam logic [17:0] C_IWB     = 18'b00000_00_0_00_00_1_00_00_0;
    localparam logic [17:0] C_BR_T    = 18'b00001_01_1_00_01_0_00_00_0;
    localparam logic [17:0] C_BR_N    = 18'b00000_01_1_00_01_0_00_00_0;
    localparam logic [17:0] C_JAL     = 18'b00001_10_0_00_00_1_10_10_0;
    localparam logic [17:0] C_JR      = 18'b00001_11_0_00_00_0_00_00_0;

    logic        clk, rst_n;
    logic [31:0] cnt;
    logic [1:0]  cnt2;
    logic [17:0] ctl;
    logic [31:0] exp_cnt;
    int          errors, checks;
    exp_t        q[$];

    mc_ctrl_if bus ();
    mc_ctrl_if bus2 ();

    mc_ctrl dut (.Clk(clk), .Rst_n(rst_n), .bus(bus.master), .RetireCnt(cnt));
    mc_ctrl #(.RETIRE_W(2)) dut2 (.Clk(clk), .Rst_n(rst_n), .bus(bus2.master), .RetireCnt(cnt2));

    assign bus2.OpCode   = bus.OpCode;
    assign bus2.Funct    = bus.Funct;
    assign bus2.Zero     = bus.Zero;
    assign bus2.MemReady = bus.MemReady;
    assign ctl = {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.PCSource,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.RegDst, bus.MemtoReg,
                  bus.Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (ctl !== x.ctl) begin
                errors++;
                $display("FAIL %s ctl got=%b exp=%b", x.nm, ctl, x.ctl);
            end
            checks++;
            if (cnt !== x.cnt) begin
                errors++;
                $display("FAIL %s retire got=%0d exp=%0d", x.nm, cnt, x.cnt);
            end
            checks++;
            if (cnt2 !== x.cnt[1:0]) begin
                errors++;
                $display("FAIL %s retire2 got=%0d exp=%0d", x.nm, cnt2, x.cnt[1:0]);
            end
        end
    end

    // inputs apply to the cycle starting at this edge; expected outputs for that cycle are queued
    task automatic cyc(input bit ret, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic z, input logic [17:0] c, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        bus.OpCode   = op;
        bus.Funct    = fn;
        bus.MemReady = rdy;
        bus.Zero     = z;
        if (ret) exp_cnt = exp_cnt + 1;
        x.nm  = nm;
        x.ctl = c;
        x.cnt = exp_cnt;
        q.push_back(x);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        bus.OpCode = '0;
        bus.Funct = '0;
        bus.MemReady = 1'b0;
        bus.Zero = 1'b0;
        cyc(0, 6'h00, 6'h20, 1, 0, C_IDLE,    "rst_idle");
        rst_n = 1'b1;
        cyc(0, 6'h00, 6'h20, 1, 0, C_FETCH,   "add_fetch");
        cyc(0, 6'h00, 6'h20, 1, 0, C_DECODE,  "add_decode");
        cyc(0, 6'h00, 6'h20, 1, 0, C_EXEC_R,  "add_exec");
        cyc(0, 6'h00, 6'h20, 1, 0, C_RWB,     "add_wb");
        cyc(1, 6'h23, 6'h00, 1, 0, C_FETCH,   "lw_fetch");
        cyc(0, 6'h23, 6'h00, 1, 0, C_DECODE,  "lw_decode");
        cyc(0, 6'h23, 6'h00, 0, 0, C_MEMADR,  "lw_memadr");
        cyc(0, 6'h23, 6'h00, 0, 0, C_MEMRD,   "lw_rd_wait1");
        cyc(0, 6'h23, 6'h00, 0, 0, C_MEMRD,   "lw_rd_wait2");
        cyc(0, 6'h23, 6'h00, 0, 0, C_MEMRD,   "lw_rd_wait3");
        cyc(0, 6'h23, 6'h00, 1, 0, C_MEMRD,   "lw_rd_done");
        cyc(0, 6'h23, 6'h00, 1, 0, C_MEMWB,   "lw_wb");
        cyc(1, 6'h04, 6'h00, 1, 1, C_FETCH,   "beq_fetch");
        cyc(0, 6'h04, 6'h00, 1, 1, C_DECODE,  "beq_decode");
        cyc(0, 6'h04, 6'h00, 1, 1, C_BR_T,    "beq_taken");
        cyc(1, 6'h05, 6'h00, 1, 1, C_FETCH,   "bne_fetch");
        cyc(0, 6'h05, 6'h00, 1, 1, C_DECODE,  "bne_decode");
        cyc(0, 6'h05, 6'h00, 1, 1, C_BR_N,    "bne_not_taken");
        cyc(1, 6'h03, 6'h00, 1, 0, C_FETCH,   "jal_fetch_wrap2");
        cyc(0, 6'h03, 6'h00, 1, 0, C_DECODE,  "jal_decode");
        cyc(0, 6'h3f, 6'h3f, 1, 0, C_JAL,     "jal_jump_latched");
        cyc(1, 6'h00, 6'h08, 0, 0, C_FETCH_W, "jr_fetch_wait");
        cyc(0, 6'h00, 6'h08, 1, 0, C_FETCH,   "jr_fetch");
        cyc(0, 6'h00, 6'h08, 1, 0, C_DECODE,  "jr_decode");
        cyc(0, 6'h00, 6'h08, 1, 0, C_JR,      "jr_jump");
        cyc(1, 6'h3f, 6'h00, 1, 0, C_FETCH,   "ill_op_fetch");
        cyc(0, 6'h3f, 6'h00, 1, 0, C_DEC_ILL, "ill_op_decode");
        cyc(0, 6'h00, 6'h01, 1, 0, C_FETCH,   "ill_fn_fetch");
        cyc(0, 6'h00, 6'h01, 1, 0, C_DEC_ILL, "ill_fn_decode");
        cyc(0, 6'h08, 6'h00, 1, 0, C_FETCH,   "addi_fetch");
        cyc(0, 6'h08, 6'h00, 1, 0, C_DECODE,  "addi_decode");
        cyc(0, 6'h08, 6'h00, 1, 0, C_EXEC_I,  "addi_exec");
        cyc(0, 6'h08, 6'h00, 1, 0, C_IWB,     "addi_wb");
        cyc(1, 6'h2b, 6'h00, 1, 0, C_FETCH,   "sw_fetch");
        cyc(0, 6'h2b, 6'h00, 1, 0, C_DECODE,  "sw_decode");
        cyc(0, 6'h2b, 6'h00, 1, 0, C_MEMADR,  "sw_memadr");
        cyc(0, 6'h2b, 6'h00, 1, 0, C_MEMWR,   "sw_wr");
        cyc(1, 6'h2b, 6'h00, 1, 0, C_FETCH,   "sw2_fetch");
        cyc(0, 6'h2b, 6'h00, 1, 0, C_DECODE,  "sw2_decode");
        cyc(0, 6'h2b, 6'h00, 1, 0, C_MEMADR,  "sw2_memadr");
        cyc(0, 6'h2b, 6'h00, 0, 0, C_MEMWR,   "sw2_wr_wait1");
        cyc(0, 6'h2b, 6'h00, 0, 0, C_MEMWR,   "sw2_wr_wait2");
        rst_n = 1'b0;
        exp_cnt = 0;
        cyc(0, 6'h2b, 6'h00, 0, 0, C_IDLE,    "rst_mid_op");
        rst_n = 1'b1;
        cyc(0, 6'h0f, 6'h00, 1, 0, C_FETCH,   "post_rst_fetch");
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
